// File: rtl/display_tx_port_pkg.sv
// Shared definitions for the terminal transmit port: FSM states, character
// constants and the lower-to-upper case fold used on CPU writes.
package display_tx_port_pkg;

  localparam int DEF_CHAR_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD     = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_RELEASE  = 2'd3
  } tx_state_t;

  localparam logic [6:0] LC_A     = 7'h61;
  localparam logic [6:0] LC_Z     = 7'h7A;
  localparam logic [6:0] CASE_OFS = 7'h20;

  // The terminal has no lower-case glyphs, so 'a'..'z' are shown as 'A'..'Z'.
  function automatic logic [6:0] fold_upper(input logic [6:0] c);
    return ((c >= LC_A) && (c <= LC_Z)) ? (c - CASE_OFS) : c;
  endfunction

endpackage

// File: rtl/display_tx_port_char_fifo.sv
// Synchronous character queue with push/pop/flush; a push while full is
// accepted only when a pop frees a slot in the same cycle.
module char_fifo import display_tx_port_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 7
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [WIDTH-1:0]           i_din,
  output logic [WIDTH-1:0]           o_dout,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/display_tx_port.sv
// CPU-side display port: queues written characters and hands them to the
// video terminal over the da / rda_n handshake, one character per ack.
module display_tx_port import display_tx_port_pkg::*; #(
  parameter int FIFO_DEPTH = 16,
  parameter int CHAR_W     = DEF_CHAR_W,
  parameter int FOLD_LC    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              flush,
  input  logic              rda_n,
  output logic              da,
  output logic [CHAR_W-1:0] rd,
  output logic              busy,
  output logic              full,
  output logic              overflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_t         r_state;
  tx_state_t         w_state_nxt;
  logic              r_da;
  logic              w_da_nxt;
  logic [CHAR_W-1:0] r_rd;
  logic              r_overflow;
  logic              w_pop;
  logic              w_push;
  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_count;
  logic [CHAR_W-1:0] w_char;
  logic [CHAR_W-1:0] w_head;
  logic              w_unused_b7;

  // Bit 7 of the CPU byte carries no meaning for the terminal.
  assign w_unused_b7 = wr_data[7];
  assign w_char = (FOLD_LC != 0) ? CHAR_W'(fold_upper(wr_data[6:0]))
                                 : wr_data[CHAR_W-1:0];

  // A write coinciding with flush is discarded silently.
  assign w_push = wr_en & ~flush;

  char_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CHAR_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (flush),
    .i_din   (w_char),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_da_nxt    = r_da;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && rda_n && !flush) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_da_nxt    = 1'b1;
        w_state_nxt = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (!rda_n) begin
          w_da_nxt    = 1'b0;
          w_state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (rda_n) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_da_nxt    = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_da       <= 1'b0;
      r_rd       <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_da       <= w_da_nxt;
      if (w_pop) r_rd <= w_head;
      r_overflow <= w_push & w_full & ~w_pop;
    end
  end

  assign da       = r_da;
  assign rd       = r_rd;
  assign full     = w_full;
  assign overflow = r_overflow;
  assign busy     = (r_state != ST_IDLE) | (w_count != '0);

endmodule

// File: tb/tb_display_tx_port.sv
// Bench for display_tx_port: fold table, directed handshake corners and a
// randomized run checked against a queue-based reference model.
module tb_display_tx_port;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       flush;
  logic       rda_n;
  logic       da, busy, full, overflow;
  logic [6:0] rd;
  logic       da_nf, busy_nf, full_nf, ovf_nf;
  logic [6:0] rd_nf;

  always #5 clk = ~clk;

  display_tx_port #(.FIFO_DEPTH(DEPTH), .CHAR_W(7), .FOLD_LC(1)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .rda_n(rda_n), .da(da), .rd(rd), .busy(busy), .full(full), .overflow(overflow)
  );

  display_tx_port #(.FIFO_DEPTH(DEPTH), .CHAR_W(7), .FOLD_LC(0)) dut_nf (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .rda_n(rda_n), .da(da_nf), .rd(rd_nf), .busy(busy_nf), .full(full_nf),
    .overflow(ovf_nf)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: pending characters plus the progress of the one on the wire.
  logic [6:0] mq [$];
  int         m_stage;   // 0 none, 1 latched, 2 presented, 3 acked waiting release
  logic       m_da;
  logic [6:0] m_rd;
  logic       m_ovf;

  typedef struct {
    logic [7:0] din;
    logic [6:0] exp_fold;
    logic [6:0] exp_raw;
  } vec_t;
  vec_t vecs [8];

  function automatic logic [6:0] ref_fold(input logic [7:0] d);
    int c;
    c = int'(d) % 128;
    if (c >= 97 && c <= 122) c = c - 32;
    return 7'(c);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_stage = 0;
    m_da    = 1'b0;
    m_rd    = '0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_edge();
    bit pop;
    pop   = (m_stage == 0) && (mq.size() > 0) && (rda_n === 1'b1) && (flush !== 1'b1);
    m_ovf = (wr_en === 1'b1) && (flush !== 1'b1) && (mq.size() == DEPTH) && !pop;
    if (pop) m_rd = mq.pop_front();
    if (flush === 1'b1) mq.delete();
    else if (wr_en === 1'b1 && !m_ovf) mq.push_back(ref_fold(wr_data));
    case (m_stage)
      0: if (pop) m_stage = 1;
      1: begin m_da = 1'b1; m_stage = 2; end
      2: if (rda_n === 1'b0) begin m_da = 1'b0; m_stage = 3; end
      default: if (rda_n === 1'b1) m_stage = 0;
    endcase
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    chk("da", da, m_da);
    chk("rd", rd, m_rd);
    chk("busy", busy, (m_stage != 0) || (mq.size() != 0));
    chk("full", full, mq.size() == DEPTH);
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic wait_da(input string name);
    int n;
    n = 0;
    while (da !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    chk({name, "_da_timeout"}, da, 1);
  endtask

  task automatic ack_one(input logic [6:0] exp);
    wait_da("ack");
    chk("ack_rd", rd, exp);
    rda_n = 1'b0;
    cyc();
    chk("ack_da_fall", da, 0);
    rda_n = 1'b1;
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h41, 7'h41, 7'h41};
    vecs[1] = '{8'hE1, 7'h41, 7'h61};
    vecs[2] = '{8'h61, 7'h41, 7'h61};
    vecs[3] = '{8'h7A, 7'h5A, 7'h7A};
    vecs[4] = '{8'h7B, 7'h7B, 7'h7B};
    vecs[5] = '{8'h60, 7'h60, 7'h60};
    vecs[6] = '{8'h0D, 7'h0D, 7'h0D};
    vecs[7] = '{8'hFA, 7'h5A, 7'h7A};

    reset = 1'b0; wr_en = 1'b0; wr_data = '0; flush = 1'b0; rda_n = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_da", da, 0);
    chk("rst_rd", rd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    reset = 1'b1;
    cyc();

    // Single characters: latency, folding, ack timing, busy clearing.
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = vecs[i].din;
      cyc();
      wr_en = 1'b0;
      chk("lat_busy", busy, 1);
      chk("lat_da0", da, 0);
      cyc();
      chk("lat_da1", da, 0);
      cyc();
      chk("lat_da_rise", da, 1);
      chk("fold_rd", rd, vecs[i].exp_fold);
      chk("nofold_rd", rd_nf, vecs[i].exp_raw);
      repeat (3) cyc();
      rda_n = 1'b0;
      cyc();
      chk("da_fall", da, 0);
      rda_n = 1'b1;
      cyc();
      chk("busy_end", busy, 0);
    end

    // Fill: one character in flight plus a full queue, then one more drops.
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h30 + i);
      cyc();
      chk("fill_no_ovf", overflow, 0);
    end
    chk("fill_full", full, 1);
    wr_data = 8'h41;
    cyc();
    wr_en = 1'b0;
    chk("ovf_pulse", overflow, 1);
    cyc();
    chk("ovf_one_cycle", overflow, 0);
    for (int i = 0; i < 17; i++) ack_one(7'(8'h30 + i));
    chk("fill_drained", busy, 0);

    // rda_n held low after the ack: nothing new until it returns high.
    wr_en = 1'b1; wr_data = 8'h55; cyc();
    wr_data = 8'h56; cyc();
    wr_en = 1'b0;
    wait_da("hold");
    chk("hold_first_rd", rd, 7'h55);
    rda_n = 1'b0;
    cyc();
    chk("hold_da_fall", da, 0);
    repeat (10) begin
      cyc();
      chk("hold_da", da, 0);
      chk("hold_rd", rd, 7'h55);
    end
    rda_n = 1'b1;
    cyc();
    cyc();
    chk("hold_next_rd", rd, 7'h56);
    chk("hold_next_da0", da, 0);
    cyc();
    chk("hold_next_da", da, 1);
    rda_n = 1'b0; cyc();
    rda_n = 1'b1; cyc();
    chk("hold_busy_end", busy, 0);

    // flush while presenting a character with five more queued.
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h61 + i);
      cyc();
    end
    wr_en = 1'b0;
    wait_da("flush");
    chk("flush_cur_rd", rd, 7'h41);
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'h5A;
    cyc();
    flush = 1'b0; wr_en = 1'b0;
    chk("flush_full", full, 0);
    chk("flush_no_ovf", overflow, 0);
    chk("flush_inflight_da", da, 1);
    chk("flush_inflight_busy", busy, 1);
    rda_n = 1'b0; cyc();
    rda_n = 1'b1; cyc();
    repeat (8) begin
      cyc();
      chk("flush_no_da", da, 0);
    end
    chk("flush_busy", busy, 0);

    // Asynchronous reset in the middle of a transfer.
    wr_en = 1'b1; wr_data = 8'h52; cyc();
    wr_data = 8'h53; cyc();
    wr_en = 1'b0;
    wait_da("rst");
    #2 reset = 1'b0;
    #1;
    chk("rst_async_da", da, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_full", full, 0);
    #2 reset = 1'b1;
    model_reset();
    wr_en = 1'b1; wr_data = 8'h0D; cyc();
    wr_en = 1'b0;
    cyc();
    cyc();
    chk("cr_da", da, 1);
    ack_one(7'h0D);
    chk("cr_busy", busy, 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      wr_en   = ($urandom_range(0, 1) == 0);
      wr_data = 8'($urandom);
      flush   = ($urandom_range(0, 79) == 0);
      if (rda_n && da && $urandom_range(0, 2) == 0) rda_n = 1'b0;
      else if (!rda_n && $urandom_range(0, 1) == 0) rda_n = 1'b1;
      else if (rda_n && !da && $urandom_range(0, 19) == 0) rda_n = 1'b0;
      cyc();
    end
    wr_en = 1'b0; flush = 1'b0;
    for (int c = 0; c < 400 && busy !== 1'b0; c++) begin
      rda_n = (da === 1'b1) ? 1'b0 : 1'b1;
      cyc();
    end
    chk("drain_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
